// File: rtl/logisim_clk_pkg.sv
// ============================================================================
//  Module      : logisim_clk_pkg
//  Description : Shared types and constants for the derived-clock tick logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logisim_clk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        ACK  = 2'd3
    } tick_state_t;

    localparam int TICK_COUNT_WIDTH   = 32;
    localparam int DEFAULT_DIV_WIDTH  = 16;
    localparam int DEFAULT_STEP_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/logisim_tick_generator_if.sv
// ============================================================================
//  Module      : logisim_tick_generator_if
//  Description : Control/step handshake bundle between debug logic and the
//                tick generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logisim_tick_generator_if
    import logisim_clk_pkg::*;
#(
    parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH,
    parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH
);
    logic [DIV_WIDTH-1:0]        Divider;
    logic                        RunEn;
    logic                        StepReq;
    logic [STEP_WIDTH-1:0]       StepCount;
    logic                        StepAck;
    logic                        ClockTick;
    logic                        Running;
    logic [TICK_COUNT_WIDTH-1:0] TickCount;

    modport master (
        output Divider, RunEn, StepReq, StepCount,
        input  StepAck, ClockTick, Running, TickCount
    );

    modport slave (
        input  Divider, RunEn, StepReq, StepCount,
        output StepAck, ClockTick, Running, TickCount
    );
endinterface

`default_nettype wire

// File: rtl/logisim_tick_prescaler.sv
// ============================================================================
//  Module      : logisim_tick_prescaler
//  Description : Reloadable down-counter producing a registered tick every
//                divider_i+1 enabled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logisim_tick_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 load_i,
    input  wire logic                 enable_i,
    input  wire logic [DIV_WIDTH-1:0] divider_i,
    output logic                      tick_o,
    output logic                      wrap_o
);
    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;
    logic                 tick_q;

    // wrap_o marks the edge on which the tick is registered, so the owner can
    // account for it in the same cycle rather than one cycle late.
    assign wrap_o = enable_i && (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = divider_i;
        end else if (enable_i) begin
            count_d = wrap_o ? divider_i : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= !load_i && wrap_o;
        end
    end

    assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/logisim_tick_generator.sv
// ============================================================================
//  Module      : logisim_tick_generator
//  Description : ClockTick source with free-run, stop and counted single-step;
//                LOGISIM_TICK_COUNTER_EN enables the 32-bit TickCount.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logisim_tick_generator
    import logisim_clk_pkg::*;
#(
    parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH,
    parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH
) (
    input  wire logic               GlobalClock,
    input  wire logic               ResetN,
    logisim_tick_generator_if.slave bus
);
    tick_state_t           state_q;
    logic [STEP_WIDTH-1:0] remaining_q;
    logic                  step_ack_q;
    logic                  running_q;

    logic w_load;
    logic w_enable;
    logic w_wrap;
    logic w_tick;

    assign w_enable = (state_q == RUN) || (state_q == STEP);
    assign w_load   = (state_q == IDLE) && (bus.RunEn || bus.StepReq);

    logisim_tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk       (GlobalClock),
        .rst_n     (ResetN),
        .load_i    (w_load),
        .enable_i  (w_enable),
        .divider_i (bus.Divider),
        .tick_o    (w_tick),
        .wrap_o    (w_wrap)
    );

    always_ff @(posedge GlobalClock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            step_ack_q  <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.RunEn) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (bus.StepReq) begin
                        state_q     <= STEP;
                        running_q   <= 1'b1;
                        remaining_q <= (bus.StepCount == '0) ? STEP_WIDTH'(1) : bus.StepCount;
                    end
                end
                RUN: begin
                    if (!bus.RunEn) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                end
                STEP: begin
                    // A step always runs to completion; RunEn is only seen again in IDLE.
                    if (w_wrap) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == STEP_WIDTH'(1)) begin
                            state_q    <= ACK;
                            running_q  <= 1'b0;
                            step_ack_q <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!bus.StepReq) begin
                        state_q    <= IDLE;
                        step_ack_q <= 1'b0;
                    end else begin
                        step_ack_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    running_q  <= 1'b0;
                    step_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ClockTick = w_tick;
    assign bus.StepAck   = step_ack_q;
    assign bus.Running   = running_q;

`ifdef LOGISIM_TICK_COUNTER_EN
    logic [TICK_COUNT_WIDTH-1:0] tick_count_q;

    always_ff @(posedge GlobalClock or negedge ResetN) begin
        if (!ResetN) begin
            tick_count_q <= '0;
        end else if (w_tick) begin
            tick_count_q <= tick_count_q + 1'b1;
        end
    end

    assign bus.TickCount = tick_count_q;
`else
    assign bus.TickCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logisim_tick_generator.sv
// ============================================================================
//  Module      : tb_logisim_tick_generator
//  Description : Directed self-checking bench for logisim_tick_generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logisim_tick_generator;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

`ifdef LOGISIM_TICK_COUNTER_EN
    localparam logic [31:0] EXP_TC10 = 32'd10;
`else
    localparam logic [31:0] EXP_TC10 = 32'd0;
`endif

    logisim_tick_generator_if #(.DIV_WIDTH(16), .STEP_WIDTH(8)) bus ();

    logisim_tick_generator #(
        .DIV_WIDTH  (16),
        .STEP_WIDTH (8)
    ) dut (
        .GlobalClock (clk),
        .ResetN      (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic tick, input logic run, input logic ack);
        chk({tag, "_tick"}, {31'd0, bus.ClockTick}, {31'd0, tick});
        chk({tag, "_running"}, {31'd0, bus.Running}, {31'd0, run});
        chk({tag, "_ack"}, {31'd0, bus.StepAck}, {31'd0, ack});
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.RunEn     = 1'b1;
        bus.StepReq   = 1'b0;
        bus.StepCount = 8'd0;
        bus.Divider   = 16'd3;
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_tickcount", bus.TickCount, 32'd0);

        // Free run, Divider=3: ticks on the 4th edge after entry, then every 4.
        rst_n = 1'b1;
        step();
        chk_out("run3_entry", 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("run3_tick", {31'd0, bus.ClockTick}, {31'd0, (k % 4) == 0});
        end
        step();
        chk("run3_tickcount", bus.TickCount, EXP_TC10);
        bus.RunEn = 1'b0;
        step();
        chk_out("run3_stop", 1'b0, 1'b0, 1'b0);

        // Divider=0: tick every cycle, last one still issued on the stopping edge.
        bus.Divider = 16'd0;
        bus.RunEn   = 1'b1;
        step();
        chk_out("run0_entry", 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("run0_tick", {31'd0, bus.ClockTick}, 32'd1);
            chk("run0_running", {31'd0, bus.Running}, {31'd0, k < 8});
            if (k == 7) bus.RunEn = 1'b0;
        end
        step();
        chk_out("run0_idle", 1'b0, 1'b0, 1'b0);

        // Step of 3 with Divider=2.
        bus.StepReq   = 1'b1;
        bus.StepCount = 8'd3;
        bus.Divider   = 16'd2;
        step();
        chk_out("step3_entry", 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_out("step3_run", (k % 3) == 0, 1'b1, 1'b0);
        end
        step();
        chk_out("step3_last", 1'b1, 1'b0, 1'b1);
        step();
        chk_out("step3_ack", 1'b0, 1'b0, 1'b1);
        bus.StepReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_out("step3_done", 1'b0, 1'b0, 1'b0);
        end

        // StepCount=0 behaves as 1; RunEn during STEP/ACK is deferred.
        bus.StepCount = 8'd0;
        bus.Divider   = 16'd1;
        bus.StepReq   = 1'b1;
        step();
        chk_out("step0_entry", 1'b0, 1'b1, 1'b0);
        bus.RunEn = 1'b1;
        step();
        chk_out("step0_wait", 1'b0, 1'b1, 1'b0);
        step();
        chk_out("step0_tick", 1'b1, 1'b0, 1'b1);
        step();
        chk_out("step0_ack", 1'b0, 1'b0, 1'b1);
        bus.StepReq = 1'b0;
        bus.Divider = 16'd5;
        step();
        chk_out("step0_release", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("step0_run", 1'b0, 1'b1, 1'b0);

        // Divider 5->1 mid-count: current 6-cycle period completes, then 2-cycle.
        for (int k = 6; k <= 22; k++) begin
            step();
            chk("divchg_tick", {31'd0, bus.ClockTick},
                {31'd0, (k == 11) || (k == 17) || (k == 19) || (k == 21)});
            if (k == 13) bus.Divider = 16'd1;
        end
        bus.RunEn = 1'b0;
        step();
        chk_out("divchg_stop", 1'b1, 1'b0, 1'b0);
        step();
        chk_out("divchg_idle", 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-step with two ticks left.
        bus.StepReq   = 1'b1;
        bus.StepCount = 8'd4;
        bus.Divider   = 16'd1;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_out("rststep_run", (k % 2) == 0, 1'b1, 1'b0);
        end
        #2;
        rst_n       = 1'b0;
        bus.StepReq = 1'b0;
        #1;
        chk_out("rststep_async", 1'b0, 1'b0, 1'b0);
        chk("rststep_tickcount", bus.TickCount, 32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_out("rststep_quiet", 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
